// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Brief    : Async-FIFO read-side controller: write-pointer synchroniser, read
//            pointer (binary + Gray), empty/almost_empty/underflow, data register.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
    parameter int PTR_WIDTH = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_en,
    input  logic [PTR_WIDTH:0]   i_wr_ptr_gray,
    input  logic [7:0]           i_mem_rdata,
    output logic [PTR_WIDTH-1:0] o_rd_addr,
    output logic [PTR_WIDTH:0]   o_rd_ptr_gray,
    output logic [7:0]           o_dout,
    output logic                 o_dout_valid,
    output logic                 o_empty,
    output logic                 o_almost_empty,
    output logic                 o_underflow
);

    localparam logic [PTR_WIDTH:0] c_AE_THRESH = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] r_sync1;
    logic [PTR_WIDTH:0] r_wq2;
    logic [PTR_WIDTH:0] r_rd_bin;
    logic [PTR_WIDTH:0] r_rd_ptr_gray;
    logic               r_empty;
    logic               r_almost_empty;
    logic [7:0]         r_dout;
    logic               r_dout_valid;
    logic               r_underflow;

    logic               w_rd_ok;
    logic [PTR_WIDTH:0] w_rd_bin_next;
    logic [PTR_WIDTH:0] w_gray_next;
    logic [PTR_WIDTH:0] w_wq2_bin;
    logic [PTR_WIDTH:0] w_level_next;

    assign w_rd_ok       = i_rd_en & ~r_empty;
    assign w_rd_bin_next = r_rd_bin + (PTR_WIDTH+1)'(w_rd_ok);
    assign w_gray_next   = w_rd_bin_next ^ (w_rd_bin_next >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_g2b
        assign w_wq2_bin[i] = ^(r_wq2 >> i);
    end

    assign w_level_next = w_wq2_bin - w_rd_bin_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1        <= '0;
            r_wq2          <= '0;
            r_rd_bin       <= '0;
            r_rd_ptr_gray  <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_dout         <= '0;
            r_dout_valid   <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_sync1        <= i_wr_ptr_gray;
            r_wq2          <= r_sync1;
            r_rd_bin       <= w_rd_bin_next;
            r_rd_ptr_gray  <= w_gray_next;
            r_empty        <= (w_gray_next == r_wq2);
            r_almost_empty <= (w_level_next <= c_AE_THRESH);
            r_dout_valid   <= w_rd_ok;
            r_underflow    <= i_rd_en & r_empty;
            if (w_rd_ok) begin
                r_dout <= i_mem_rdata;
            end
        end
    end

    assign o_rd_addr      = r_rd_bin[PTR_WIDTH-1:0];
    assign o_rd_ptr_gray  = r_rd_ptr_gray;
    assign o_dout         = r_dout;
    assign o_dout_valid   = r_dout_valid;
    assign o_empty        = r_empty;
    assign o_almost_empty = r_almost_empty;
    assign o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Brief    : Self-checking bench for fifo_rd_ctrl with a pointer-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    int         wr_bin;
    logic [4:0] wr_gray;
    logic [7:0] mem_rdata;
    logic [3:0] o_rd_addr;
    logic [4:0] o_rd_ptr_gray;
    logic [7:0] o_dout;
    logic       o_dout_valid, o_empty, o_almost_empty, o_underflow;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    assign wr_gray   = to_gray(wr_bin);
    assign mem_rdata = 8'hA0 + {4'h0, o_rd_addr};

    fifo_rd_ctrl #(.PTR_WIDTH(4), .AE_THRESH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd_en        (rd_en),
        .i_wr_ptr_gray  (wr_gray),
        .i_mem_rdata    (mem_rdata),
        .o_rd_addr      (o_rd_addr),
        .o_rd_ptr_gray  (o_rd_ptr_gray),
        .o_dout         (o_dout),
        .o_dout_valid   (o_dout_valid),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_underflow    (o_underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: read count, and the write count as seen after two sampling stages.
    int         m_rd, m_s1, m_s2;
    logic       m_empty, m_ae, m_dv, m_uf;
    logic [7:0] m_dout;

    always @(posedge clk) begin
        int nxt;
        bit ok;
        if (rst) begin
            m_rd = 0; m_s1 = 0; m_s2 = 0;
            m_empty = 1'b1; m_ae = 1'b1; m_dv = 1'b0; m_uf = 1'b0; m_dout = 8'h00;
        end else begin
            ok   = rd_en && !m_empty;
            nxt  = (m_rd + (ok ? 1 : 0)) % 32;
            m_uf = rd_en && m_empty;
            m_dv = ok;
            if (ok) m_dout = 8'(8'hA0 + m_rd % 16);
            m_empty = (m_s2 == nxt);
            m_ae    = ((m_s2 - nxt + 32) % 32) <= 2;
            m_rd    = nxt;
            m_s2    = m_s1;
            m_s1    = wr_bin % 32;
        end
        #1;
        if (chk_en) begin
            chk("m_rd_addr", int'(o_rd_addr), m_rd % 16);
            chk("m_rd_gray", int'(o_rd_ptr_gray), int'(to_gray(m_rd)));
            chk("m_dout", int'(o_dout), int'(m_dout));
            chk("m_dout_valid", int'(o_dout_valid), int'(m_dv));
            chk("m_empty", int'(o_empty), int'(m_empty));
            chk("m_almost_empty", int'(o_almost_empty), int'(m_ae));
            chk("m_underflow", int'(o_underflow), int'(m_uf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && o_empty; i++) tick();
        chk("ready_timeout", int'(o_empty), 0);
    endtask

    task automatic reset_with(input int wb);
        rst = 1'b1; rd_en = 1'b0; wr_bin = wb;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_bin = 2;
        @(posedge clk);
        chk_en = 1'b1;
        #2;
        // Reset and empty-release latency
        repeat (4) tick();
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_addr", int'(o_rd_addr), 0);
        chk("rst_gray", int'(o_rd_ptr_gray), 0);
        rst = 1'b0;
        tick(); chk("rel_edge1_empty", int'(o_empty), 1);
        tick(); chk("rel_edge2_empty", int'(o_empty), 1);
        tick(); chk("rel_edge3_empty", int'(o_empty), 0);

        // Single read
        reset_with(1);
        wait_ready();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("single_addr", int'(o_rd_addr), 1);
        chk("single_gray", int'(o_rd_ptr_gray), 5'b00001);
        chk("single_empty", int'(o_empty), 1);
        chk("single_dout", int'(o_dout), 8'hA0);
        chk("single_dv", int'(o_dout_valid), 1);
        tick(); chk("single_dv_drop", int'(o_dout_valid), 0);

        // Underflow
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("uf_flag", int'(o_underflow), 1);
            chk("uf_addr", int'(o_rd_addr), 1);
            chk("uf_dv", int'(o_dout_valid), 0);
        end
        rd_en = 1'b0;
        tick(); chk("uf_clear", int'(o_underflow), 0);

        // Wrap
        reset_with(16);
        wait_ready();
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("wrap_dout", int'(o_dout), 8'hA0 + k);
        end
        rd_en = 1'b0;
        chk("wrap_addr", int'(o_rd_addr), 0);
        chk("wrap_gray", int'(o_rd_ptr_gray), 5'b11000);
        chk("wrap_empty", int'(o_empty), 1);
        wr_bin = 20;
        wait_ready();
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap2_dout", int'(o_dout), 8'hA0 + k);
        end
        rd_en = 1'b0;
        chk("wrap2_gray", int'(o_rd_ptr_gray), 5'b11110);
        tick();

        // almost_empty
        reset_with(3);
        wait_ready();
        chk("ae_level3", int'(o_almost_empty), 0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("ae_level2", int'(o_almost_empty), 1);
        chk("ae_level2_empty", int'(o_empty), 0);
        tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("ae_level1", int'(o_almost_empty), 1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("ae_level0_empty", int'(o_empty), 1);

        // Mid-burst reset
        reset_with(16);
        wait_ready();
        rd_en = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mbr_addr", int'(o_rd_addr), 0);
        chk("mbr_gray", int'(o_rd_ptr_gray), 0);
        chk("mbr_dv", int'(o_dout_valid), 0);
        chk("mbr_dout", int'(o_dout), 0);
        chk("mbr_empty", int'(o_empty), 1);
        chk("mbr_ae", int'(o_almost_empty), 1);
        rst = 1'b0; rd_en = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
